lbus_arb_2to1: RTL
==================

LBUS_ARB_2TO1 -- requirements
Module: lbus_arb_2to1

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, local-bus address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, local-bus data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, maximum target wait cycles before an access is aborted (range 1..255).
REQ-004 The block SHALL have port i_hclk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_hresetn, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports i_m0_cs / i_m1_cs, input, 1, requester access request, held high until that requester's ready.
REQ-007 The block SHALL have ports i_m0_we / i_m1_we, input, 1, write (1) or read (0).
REQ-008 The block SHALL have ports i_m0_addr / i_m1_addr, input, ADDR_W, access address.
REQ-009 The block SHALL have ports i_m0_wdata / i_m1_wdata, input, DATA_W, write data.
REQ-010 The block SHALL have ports o_m0_rdata / o_m1_rdata, output, DATA_W, read data, valid with ready.
REQ-011 The block SHALL have ports o_m0_ready / o_m1_ready, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have ports o_m0_err / o_m1_err, output, 1, one-cycle timeout pulse, coincident with ready.
REQ-013 The block SHALL have ports o_cs, o_we, o_addr, o_wdata, output, 1/1/ADDR_W/DATA_W, shared target bus.
REQ-014 The block SHALL have ports i_rdata, input, DATA_W, and i_ready, input, 1, target read data and completion.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-016 IDLE: any cs high -> latch the winner's we/addr/wdata into registers, store the grant index, go to ACCESS; no cs -> stay.
REQ-017 Arbitration SHALL be round-robin: a single requester wins outright; on a tie, the requester not granted last wins.
REQ-018 All target outputs SHALL be registered: o_cs high exactly in ACCESS, and o_we/o_addr/o_wdata stable throughout ACCESS.
REQ-019 ACCESS with i_ready=1 -> capture i_rdata, go to DONE.
REQ-020 ACCESS with a wait counter reaching TIMEOUT without i_ready -> go to DONE with the error flag set and rdata forced to 0.
REQ-021 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without i_ready.
REQ-022 DONE SHALL pulse the granted o_mX_ready (and o_mX_err if flagged) for one cycle, drive o_mX_rdata, then go to IDLE.
REQ-023 Latency: cs sampled in IDLE at cycle N -> o_cs at N+1; i_ready at cycle M -> o_mX_ready at M+1; earliest next o_cs at M+3.
REQ-024 Changes to a requester's inputs during ACCESS/DONE SHALL be ignored; a cs drop mid-access SHALL NOT abort the access.
REQ-025 The non-granted requester's ready/err SHALL stay 0, and its rdata SHALL hold its last value.
REQ-026 i_ready outside ACCESS SHALL be ignored.
REQ-027 A requester still asserting cs in the cycle after its ready SHALL be treated as a new request.

Reset
REQ-028 On i_hresetn low, the block SHALL asynchronously set state=IDLE, o_cs=0, o_we=0, o_addr=0, o_wdata=0, all rdata=0, all ready/err=0, wait counter=0, and last-grant=1 (so m0 wins the first tie).
REQ-029 Reset asserted mid-ACCESS SHALL drop o_cs immediately and produce no ready pulse after release.

Structure
REQ-030 The FSM state encoding and the TIMEOUT default SHALL reside in a shared package, lbus_pkg.
REQ-031 The round-robin decision SHALL be a sub-module, lbus_rr_arb2 (inputs req[1:0], last; output gnt index), combinational.

Verification
REQ-032 Single read: m0 cs, addr 0x100, target ready after 2 waits with rdata 0xDEADBEEF -> o_m0_rdata=0xDEADBEEF, o_m0_ready one pulse, err=0.
REQ-033 Tie after reset: both cs in the same cycle -> m0 granted first, then m1; o_addr shows m0's then m1's address.
REQ-034 Back-to-back fairness: both hold cs for 4 accesses -> grants alternate m0,m1,m0,m1.
REQ-035 Timeout: m1 write, i_ready never asserted -> o_cs high exactly 15 cycles, then o_m1_ready=o_m1_err=1 for one cycle, o_m1_rdata=0.
REQ-036 Reset mid-ACCESS: assert i_hresetn low during o_cs -> o_cs=0 at once, no ready pulses, first tie after release goes to m0.
REQ-037 Stray i_ready in IDLE and a cs drop during ACCESS -> no spurious ready; the in-flight access completes normally.

Source files
------------

// File: rtl/lbus_pkg.sv
// Shared definitions for the two-requester local-bus arbiter: FSM encoding and defaults.
package lbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lbus_state_e;

  localparam int TIMEOUT_DEF = 15;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int WAIT_W      = 8;

endpackage : lbus_pkg

// File: rtl/lbus_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to
// the requester that was not granted last.
module lbus_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule : lbus_rr_arb2

// File: rtl/lbus_arb_2to1.sv
// Two requesters share one local-bus target; round-robin grant, registered
// target interface, and a wait-cycle timeout that completes the access with err.
module lbus_arb_2to1
  import lbus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_hclk,
  input  logic              i_hresetn,
  input  logic              i_m0_cs,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_ready,
  output logic              o_m0_err,
  input  logic              i_m1_cs,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_ready,
  output logic              o_m1_err,
  output logic              o_cs,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_ready
);

  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

  lbus_state_e       state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_err_q, m1_err_d;
  logic              arb_gnt;

  lbus_rr_arb2 u_rr (
    .req  ({i_m1_cs, i_m0_cs}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wait_d     = wait_q;
    cs_d       = cs_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_m0_cs || i_m1_cs) begin
          gnt_d   = arb_gnt;
          last_d  = arb_gnt;
          we_d    = arb_gnt ? i_m1_we    : i_m0_we;
          addr_d  = arb_gnt ? i_m1_addr  : i_m0_addr;
          wdata_d = arb_gnt ? i_m1_wdata : i_m0_wdata;
          cs_d    = 1'b1;
          wait_d  = '0;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // A target ready on the final allowed wait cycle still wins over timeout.
        if (i_ready) begin
          cs_d    = 1'b0;
          state_d = ST_DONE;
          if (gnt_q) begin
            m1_rdata_d = i_rdata;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = i_rdata;
            m0_ready_d = 1'b1;
          end
        end else if (wait_q == TO_LAST) begin
          wait_d  = wait_q + 1'b1;
          cs_d    = 1'b0;
          state_d = ST_DONE;
          if (gnt_q) begin
            m1_rdata_d = '0;
            m1_ready_d = 1'b1;
            m1_err_d   = 1'b1;
          end else begin
            m0_rdata_d = '0;
            m0_ready_d = 1'b1;
            m0_err_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wait_q     <= '0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
    end
  end

  assign o_cs       = cs_q;
  assign o_we       = we_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_m0_rdata = m0_rdata_q;
  assign o_m1_rdata = m1_rdata_q;
  assign o_m0_ready = m0_ready_q;
  assign o_m1_ready = m1_ready_q;
  assign o_m0_err   = m0_err_q;
  assign o_m1_err   = m1_err_q;

endmodule : lbus_arb_2to1
